// File: rtl/swap_ctrl_if.sv
// Handshake and register-file bus for swap_ctrl.
// The slave modport is the controller's view. The master modport is the view of
// whatever issues swap requests and owns the register file.
//   start, rs_addr, rt_addr    : swap request (addresses of the pair)
//   rf_rsa/rf_rsb, rf_rd_a/b   : two combinational read ports
//   rf_wa, rf_wd, rf_we        : single write port
//   busy, done, swap_cnt       : status
interface swap_ctrl_if;
    logic        start;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic [3:0]  rf_rsa;
    logic [3:0]  rf_rsb;
    logic [31:0] rf_rd_a;
    logic [31:0] rf_rd_b;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        rf_we;
    logic        busy;
    logic        done;
    logic [7:0]  swap_cnt;

    modport slave (
        input  start, rs_addr, rt_addr, rf_rd_a, rf_rd_b,
        output rf_rsa, rf_rsb, rf_wa, rf_wd, rf_we, busy, done, swap_cnt
    );

    modport master (
        output start, rs_addr, rt_addr, rf_rd_a, rf_rd_b,
        input  rf_rsa, rf_rsb, rf_wa, rf_wd, rf_we, busy, done, swap_cnt
    );
endinterface

// File: rtl/swap_ctrl.sv
// Register swap controller. It exchanges the contents of two register-file
// entries. The controller reads both entries in one cycle and then writes each
// one back with the other's value.
//   clk    : rising-edge clock
//   rst_f  : synchronous active-low reset
//   bus    : swap_ctrl_if.slave (request, register-file ports, status)
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; latches rs/rt when start is seen
// READ   | captures both read ports into buf_a/buf_b
// WR_A   | writes buf_b to rs (suppressed if rs == 0)
// WR_B   | writes buf_a to rt (suppressed if rt == 0)
// DONE   | one-cycle done pulse, bumps swap_cnt
module swap_ctrl (
    input  logic        clk,
    input  logic        rst_f,
    swap_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WR_A = 3'd2,
        S_WR_B = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  rs_q, rs_d;
    logic [3:0]  rt_q, rt_d;
    logic [31:0] buf_a_q, buf_a_d;
    logic [31:0] buf_b_q, buf_b_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        busy;
    logic        done;

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q <= S_IDLE;
            rs_q    <= 4'd0;
            rt_q    <= 4'd0;
            buf_a_q <= 32'd0;
            buf_b_q <= 32'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        buf_a_d = buf_a_q;
        buf_b_d = buf_b_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        wa      = 4'd0;
        wd      = 32'd0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    rs_d    = bus.rs_addr;
                    rt_d    = bus.rt_addr;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                buf_a_d = bus.rf_rd_a;
                buf_b_d = bus.rf_rd_b;
                // Swapping a register with itself is a no-op, so skip the writes.
                state_d = (rs_q != rt_q) ? S_WR_A : S_DONE;
            end
            S_WR_A: begin
                wa      = rs_q;
                wd      = buf_b_q;
                // Register 0 is hard-wired, so writes to it are dropped.
                we      = (rs_q != 4'd0);
                state_d = S_WR_B;
            end
            S_WR_B: begin
                wa      = rt_q;
                wd      = buf_a_q;
                we      = (rt_q != 4'd0);
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.rf_rsa   = rs_q;
    assign bus.rf_rsb   = rt_q;
    assign bus.rf_we    = we;
    assign bus.rf_wa    = wa;
    assign bus.rf_wd    = wd;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.swap_cnt = cnt_q;

endmodule

// File: tb/tb_swap_ctrl.sv
// Bench for swap_ctrl. It holds a behavioural register file and a swap-level
// reference model.
module tb_swap_ctrl;

    localparam int BIG = 1 << 30;

    typedef struct {
        int          cyc;   // clock edge after which the event is visible
        int          kind;  // 0 write, 1 suppressed write, 2 done
        logic [3:0]  addr;
        logic [31:0] data;
    } ev_t;

    logic clk;
    logic rst_f;
    swap_ctrl_if bus ();

    swap_ctrl dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    // Register file seen by the DUT, plus a bench-side preload port.
    logic [31:0] rf_mem [16];
    logic        tb_we;
    logic [3:0]  tb_wa;
    logic [31:0] tb_wd;

    assign bus.rf_rd_a = rf_mem[bus.rf_rsa];
    assign bus.rf_rd_b = rf_mem[bus.rf_rsb];

    always @(posedge clk) begin
        if (tb_we) rf_mem[tb_wa] <= tb_wd;
        else if (bus.rf_we) rf_mem[bus.rf_wa] <= bus.rf_wd;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [31:0] m_regs [16];
    logic [7:0]  m_cnt = 8'd0;
    logic [3:0]  m_rs = 4'd0;
    logic [3:0]  m_rt = 4'd0;
    int          acc_edge = BIG;
    int          done_edge = -1;
    int          free_edge = 0;
    ev_t         q[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic push_ev(input int c, input int k, input logic [3:0] a, input logic [31:0] d);
        ev_t ev;
        ev.cyc  = c;
        ev.kind = k;
        ev.addr = a;
        ev.data = d;
        q.push_back(ev);
    endtask

    // One clock: applies inputs and predicts their effect. The inputs are
    // sampled at edge e = cyc+1.
    task automatic step(input bit st, input logic [3:0] rs, input logic [3:0] rt, input bit rn);
        int          e;
        logic [31:0] va;
        logic [31:0] vb;
        ev_t         keep[$];
        e           = cyc + 1;
        bus.start   = st;
        bus.rs_addr = rs;
        bus.rt_addr = rt;
        rst_f       = rn;
        if (!rn) begin
            foreach (q[i]) if (q[i].cyc < e) keep.push_back(q[i]);
            q         = keep;
            m_cnt     = 8'd0;
            m_rs      = 4'd0;
            m_rt      = 4'd0;
            acc_edge  = BIG;
            done_edge = -1;
            free_edge = e + 1;
        end else if (st && e >= free_edge) begin
            m_rs     = rs;
            m_rt     = rt;
            acc_edge = e;
            va       = m_regs[rs];
            vb       = m_regs[rt];
            if (rs != rt) begin
                push_ev(e + 1, (rs == 4'd0) ? 1 : 0, rs, vb);
                push_ev(e + 2, (rt == 4'd0) ? 1 : 0, rt, va);
                done_edge = e + 3;
            end else begin
                done_edge = e + 1;
            end
            push_ev(done_edge, 2, 4'd0, 32'd0);
            free_edge = done_edge + 2;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] a, input logic [31:0] d);
        tb_we     = 1'b1;
        tb_wa     = a;
        tb_wd     = d;
        m_regs[a] = d;
        step(1'b0, 4'd0, 4'd0, 1'b1);
        tb_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
    endtask

    // Monitor: compares every cycle against the predicted event stream.
    always @(negedge clk) begin
        if (mon_en) begin
            ev_t ev;
            bit  has;
            has = 1'b0;
            if (q.size() > 0 && q[0].cyc < cyc) begin
                ev = q.pop_front();
                chk("missed_event", 32'(ev.cyc), 32'(cyc));
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                ev  = q.pop_front();
                has = 1'b1;
            end
            chk("busy", {31'd0, bus.busy}, {31'd0, (cyc >= acc_edge && cyc <= done_edge)});
            chk("rf_rsa", {28'd0, bus.rf_rsa}, {28'd0, m_rs});
            chk("rf_rsb", {28'd0, bus.rf_rsb}, {28'd0, m_rt});
            chk("swap_cnt", {24'd0, bus.swap_cnt}, {24'd0, m_cnt});
            if (has && ev.kind == 0) begin
                chk("rf_we", {31'd0, bus.rf_we}, 32'd1);
                chk("rf_wa", {28'd0, bus.rf_wa}, {28'd0, ev.addr});
                chk("rf_wd", bus.rf_wd, ev.data);
                m_regs[ev.addr] = ev.data;
            end else begin
                chk("rf_we_low", {31'd0, bus.rf_we}, 32'd0);
                if (!(has && ev.kind == 1)) begin
                    chk("rf_wa_zero", {28'd0, bus.rf_wa}, 32'd0);
                    chk("rf_wd_zero", bus.rf_wd, 32'd0);
                end
            end
            chk("done", {31'd0, bus.done}, {31'd0, (has && ev.kind == 2)});
            if (has && ev.kind == 2) m_cnt = m_cnt + 8'd1;
        end
    end

    initial begin
        logic [31:0] r9_before;
        bit          st;
        logic [3:0]  rs;
        logic [3:0]  rt;
        tb_we       = 1'b0;
        tb_wa       = 4'd0;
        tb_wd       = 32'd0;
        bus.start   = 1'b0;
        bus.rs_addr = 4'd0;
        bus.rt_addr = 4'd0;
        rst_f       = 1'b0;

        step(1'b0, 4'd0, 4'd0, 1'b0);
        mon_en = 1'b1;
        step(1'b1, 4'd3, 4'd5, 1'b0);   // reset wins over start
        step(1'b0, 4'd0, 4'd0, 1'b1);

        preload(4'd0, 32'd0);
        for (int i = 1; i < 16; i++) preload(4'(i), $urandom);
        preload(4'd3, 32'h11111111);
        preload(4'd5, 32'h22222222);
        preload(4'd4, 32'hDEADBEEF);

        // Basic swap
        step(1'b1, 4'd3, 4'd5, 1'b1);
        idle(6);
        chk("swap_r3", rf_mem[3], 32'h22222222);
        chk("swap_r5", rf_mem[5], 32'h11111111);
        chk("swap_cnt1", {24'd0, bus.swap_cnt}, 32'd1);

        // Same register: no writes, short latency
        step(1'b1, 4'd7, 4'd7, 1'b1);
        idle(4);
        chk("same_cnt2", {24'd0, bus.swap_cnt}, 32'd2);

        // Register 0 on one side
        step(1'b1, 4'd0, 4'd4, 1'b1);
        idle(6);
        chk("zero_r4", rf_mem[4], 32'd0);
        chk("zero_r0", rf_mem[0], 32'd0);

        // Start held high: one swap per IDLE acceptance
        for (int i = 0; i < 12; i++) step(1'b1, 4'd1, 4'd2, 1'b1);
        idle(6);

        // Reset in the WR_A cycle aborts the swap
        r9_before = m_regs[9];
        step(1'b1, 4'd6, 4'd9, 1'b1);
        step(1'b0, 4'd0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 4'd0, 1'b0);
        idle(4);
        chk("abort_r6", rf_mem[6], r9_before);
        chk("abort_r9", rf_mem[9], r9_before);
        chk("abort_cnt", {24'd0, bus.swap_cnt}, 32'd0);

        // 256 back-to-back swaps wrap the counter
        for (int i = 0; i < 1280; i++) step(1'b1, 4'd1, 4'd2, 1'b1);
        idle(4);
        chk("wrap_cnt", {24'd0, bus.swap_cnt}, 32'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 700; i++) begin
            st = ($urandom_range(0, 1) == 1);
            rs = 4'($urandom_range(0, 15));
            rt = ($urandom_range(0, 7) == 0) ? rs : 4'($urandom_range(0, 15));
            step(st, rs, rt, ($urandom_range(0, 99) != 0));
        end
        idle(8);

        for (int i = 0; i < 16; i++) chk("final_reg", rf_mem[i], m_regs[i]);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/swap_ctrl.md
SWAP_CTRL -- requirements
Module: swap_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_f  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 start  input  1  swap request, sampled only in IDLE.
REQ-005 rs_addr  input  4  first register of the swap pair.
REQ-006 rt_addr  input  4  second register of the swap pair.
REQ-007 rf_rsa  output  4  register-file read address A (latched rs).
REQ-008 rf_rsb  output  4  register-file read address B (latched rt).
REQ-009 rf_rd_a  input  32  register-file read data A (combinational from rf_rsa).
REQ-010 rf_rd_b  input  32  register-file read data B (combinational from rf_rsb).
REQ-011 rf_wa  output  4  register-file write address.
REQ-012 rf_wd  output  32  register-file write data.
REQ-013 rf_we  output  1  register-file write enable, one-cycle pulses.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 swap_cnt  output  8  count of completed swaps, wraps 255->0.

Function
REQ-017 States SHALL be IDLE, READ, WR_A, WR_B, DONE; transitions only on clk rising edge.
REQ-018 IDLE with start=1 SHALL latch rs_addr/rt_addr into rs_q/rt_q and go to READ; start=0 stays IDLE.
REQ-019 rf_rsa/rf_rsb SHALL equal rs_q/rt_q in all states.
REQ-020 READ SHALL capture rf_rd_a into buf_a and rf_rd_b into buf_b; next WR_A if rs_q!=rt_q, else DONE (no writes).
REQ-021 WR_A SHALL drive rf_we=1, rf_wa=rs_q, rf_wd=buf_b; next WR_B.
REQ-022 WR_B SHALL drive rf_we=1, rf_wa=rt_q, rf_wd=buf_a; next DONE.
REQ-023 Any write whose address is 0 SHALL be suppressed (rf_we=0 that cycle); state sequence is unchanged.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, increment swap_cnt by 1 mod 256, and return to IDLE.
REQ-025 Outside WR_A/WR_B rf_we SHALL be 0 and rf_wa/rf_wd SHALL be 0.
REQ-026 start while busy=1 SHALL be ignored; no queuing.
REQ-027 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle is accepted.
REQ-028 Latency: start accepted at edge N -> READ N, WR_A N+1, WR_B N+2, done N+3 (rs!=rt); rs==rt -> done N+1.
REQ-029 rs_addr/rt_addr changes after acceptance SHALL not affect the operation in flight.

Reset
REQ-030 rst_f=0 at a clk edge SHALL force IDLE, rs_q=rt_q=0, buf_a=buf_b=0, swap_cnt=0, and all outputs 0.
REQ-031 Reset during WR_A or WR_B SHALL abort the swap; no further rf_we pulse occurs, swap_cnt not incremented.
REQ-032 rst_f=0 together with start=1 SHALL give reset priority; start is not accepted.

Verification
REQ-033 R3=0x11111111, R5=0x22222222, start rs=3 rt=5 -> WR_A writes R3=0x22222222, WR_B writes R5=0x11111111, done at start+3, swap_cnt=1.
REQ-034 start rs=7 rt=7 -> no rf_we pulse, done at start+1, swap_cnt increments.
REQ-035 start rs=0 rt=4, R4=0xDEADBEEF -> WR_A suppressed, WR_B writes R4=0x00000000 from R0, done asserted.
REQ-036 start held high through a full swap plus re-pulse during busy -> exactly one swap per IDLE acceptance; busy high 4 cycles.
REQ-037 rst_f low in WR_A cycle -> next cycle IDLE, rf_we=0, no WR_B write, swap_cnt=0.
REQ-038 256 back-to-back swaps -> swap_cnt wraps to 0 after the 256th done pulse.
